jump_physics: RTL and testbench

- Parametrised successor to the table-driven dino jump block: integrates a fixed-point kinematic jump (position and velocity) instead of a fixed 51-entry height table.
- Adds variable-height jumps (early release), fast-fall on duck, a one-deep buffered re-jump, and apex/land/falling status for the renderer and scorer.
- Sits between the input debouncer and the sprite renderer; `jump_pos` feeds the dino sprite Y offset.

---
 rtl/dino_pkg.sv | 21 ++
 rtl/jump_tick_gen.sv | 26 ++
 rtl/jump_physics.sv | 149 ++++++++++++++
 tb/tb_jump_physics.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the dino jump path: FSM states, default Q-format
// physics constants and the sprite height type used by the renderer.
package dino_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    // Q(POS_W).(FRAC_W) fixed point; velocities and gravity in the same units
    localparam int DEF_POS_W    = 7;
    localparam int DEF_FRAC_W   = 4;
    localparam int DEF_INIT_VEL = 96;   // 6.0 px/tick
    localparam int DEF_GRAVITY  = 4;    // 0.25 px/tick^2
    localparam int DEF_CUT_VEL  = 32;   // 2.0 px/tick after early release
    localparam int DEF_FF_SHIFT = 2;    // x4 gravity while ducking in air

    typedef logic [DEF_POS_W-1:0] jump_pos_t;

endpackage

// File: rtl/jump_tick_gen.sv
// Physics tick divider: one tick every speed+1 enabled cycles.
module jump_tick_gen #(
    parameter int SPEED_W = 24
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    logic [SPEED_W-1:0] ctr;

    assign tick = en && (ctr == speed);

    // Count enabled cycles, wrapping to zero on each tick; held while disabled
    always_ff @(posedge clk) begin
        if (!sys_rst_n || clr) begin
            ctr <= '0;
        end else if (en) begin
            ctr <= tick ? '0 : ctr + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/jump_physics.sv
// Fixed-point jump integrator: position/velocity with early-release cut,
// fast-fall on duck, one-deep re-jump buffer and apex/land status pulses.
module jump_physics
    import dino_pkg::*;
#(
    parameter int POS_W     = DEF_POS_W,
    parameter int FRAC_W    = DEF_FRAC_W,
    parameter int SPEED_W   = 24,
    parameter int INIT_VEL  = DEF_INIT_VEL,
    parameter int GRAVITY   = DEF_GRAVITY,
    parameter int CUT_VEL   = DEF_CUT_VEL,
    parameter int FF_SHIFT  = DEF_FF_SHIFT,
    parameter int BUFFER_EN = 1
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               game_rst,
    input  logic               jump,
    input  logic               duck,
    input  logic               halt,
    input  logic [SPEED_W-1:0] speed,
    output logic [POS_W-1:0]   jump_pos,
    output logic               in_air,
    output logic               falling,
    output logic               apex_pulse,
    output logic               land_pulse
);

    localparam int PW = POS_W + FRAC_W;   // position width
    localparam int VW = PW + 1;           // signed velocity width
    localparam int SW = PW + 2;           // signed sum width, cannot wrap

    localparam logic signed [VW-1:0] INIT_V = VW'(INIT_VEL);
    localparam logic signed [VW-1:0] CUT_V  = VW'(CUT_VEL);
    localparam logic signed [VW-1:0] G_NORM = VW'(GRAVITY);
    localparam logic signed [VW-1:0] G_FAST = VW'(GRAVITY << FF_SHIFT);

    jump_state_t            state, state_n;
    logic [PW-1:0]          pos, pos_n, pos_next;
    logic signed [VW-1:0]   vel, vel_n, v_eff, g_eff, vel_next;
    logic signed [SW-1:0]   pos_ext, v_ext, sum;
    logic                   pending, pending_n, jump_q;
    logic                   apex_n, land_n;
    logic                   launch, tick, land, ceil, vel_le0;

    jump_tick_gen #(
        .SPEED_W (SPEED_W)
    ) u_tick_gen (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .clr       (game_rst || launch),
        .en        ((state != GROUND) && !halt),
        .speed     (speed),
        .tick      (tick)
    );

    // One integration step: capped/normal velocity, gravity and candidate position
    always_comb begin
        v_eff = vel;
        if (state == RISE && !jump && vel > CUT_V) begin
            v_eff = CUT_V;
        end
        g_eff    = duck ? G_FAST : G_NORM;
        vel_next = v_eff - g_eff;
        pos_ext  = {2'b00, pos};
        v_ext    = {v_eff[VW-1], v_eff};
        sum      = pos_ext + v_ext;
        land     = sum[SW-1] || (sum == '0);
        ceil     = !sum[SW-1] && sum[SW-2];
        pos_next = ceil ? '1 : sum[PW-1:0];
        vel_le0  = vel_next[VW-1] || (vel_next == '0);
    end

    // Next-state: launch from ground, integrate on ticks, landing before apex
    always_comb begin
        state_n   = state;
        pos_n     = pos;
        vel_n     = vel;
        pending_n = pending;
        apex_n    = 1'b0;
        land_n    = 1'b0;
        launch    = 1'b0;
        if (!halt) begin
            if (BUFFER_EN != 0 && state != GROUND && jump && !jump_q) begin
                pending_n = 1'b1;
            end
            case (state)
                GROUND: begin
                    if (jump) begin
                        launch  = 1'b1;
                        state_n = RISE;
                        vel_n   = INIT_V;
                        pos_n   = '0;
                    end
                end
                RISE, FALL: begin
                    if (tick) begin
                        if (land) begin
                            pos_n     = '0;
                            land_n    = 1'b1;
                            pending_n = 1'b0;
                            if (pending || jump) begin
                                state_n = RISE;
                                vel_n   = INIT_V;
                            end else begin
                                state_n = GROUND;
                                vel_n   = '0;
                            end
                        end else begin
                            pos_n = pos_next;
                            vel_n = vel_next;
                            if (state == RISE && vel_le0) begin
                                state_n = FALL;
                                apex_n  = 1'b1;
                            end
                        end
                    end
                end
                default: state_n = GROUND;
            endcase
        end
    end

    // State and status registers; jump_q tracks the button even while halted
    always_ff @(posedge clk) begin
        if (!sys_rst_n || game_rst) begin
            state      <= GROUND;
            pos        <= '0;
            vel        <= '0;
            pending    <= 1'b0;
            jump_q     <= 1'b0;
            apex_pulse <= 1'b0;
            land_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            vel        <= vel_n;
            pending    <= pending_n;
            jump_q     <= jump;
            apex_pulse <= apex_n;
            land_pulse <= land_n;
        end
    end

    assign jump_pos = pos[PW-1:FRAC_W];
    assign in_air   = (state != GROUND);
    assign falling  = (state == FALL);

endmodule

// File: tb/tb_jump_physics.sv
// Directed bench for jump_physics: full jump, early release, fast-fall,
// buffered re-jump (with and without buffer), tick divider with halt, resets.
module tb_jump_physics;

    logic        clk = 1'b0;
    logic        sys_rst_n, game_rst, jump, duck, halt;
    logic [23:0] speed;

    logic [6:0]  jump_pos, nb_jump_pos;
    logic        in_air, falling, apex_pulse, land_pulse;
    logic        nb_in_air, nb_falling, nb_apex_pulse, nb_land_pulse;

    int total = 0;
    int bad   = 0;

    jump_physics u_dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .game_rst   (game_rst),
        .jump       (jump),
        .duck       (duck),
        .halt       (halt),
        .speed      (speed),
        .jump_pos   (jump_pos),
        .in_air     (in_air),
        .falling    (falling),
        .apex_pulse (apex_pulse),
        .land_pulse (land_pulse)
    );

    jump_physics #(
        .BUFFER_EN (0)
    ) u_dut_nb (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .game_rst   (game_rst),
        .jump       (jump),
        .duck       (duck),
        .halt       (halt),
        .speed      (speed),
        .jump_pos   (nb_jump_pos),
        .in_air     (nb_in_air),
        .falling    (nb_falling),
        .apex_pulse (nb_apex_pulse),
        .land_pulse (nb_land_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        game_rst  = 1'b0;
        jump      = 1'b0;
        duck      = 1'b0;
        halt      = 1'b0;
        speed     = '0;
        step();
        step();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({in_air, falling, apex_pulse, land_pulse, jump_pos} !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {in_air, falling, apex_pulse, land_pulse, jump_pos});
        end
    endtask

    task automatic test_full_jump();
        int apex_k = -1, land_k = -1, apex_n = 0, apex_p = -1;
        speed = '0;
        jump  = 1'b1;
        step();
        total++;
        if (in_air !== 1'b1 || jump_pos !== 7'd0) begin
            bad++;
            $display("FAIL launch got in_air=%b pos=%0d want in_air=1 pos=0", in_air, jump_pos);
        end
        for (int k = 1; k <= 60 && land_k < 0; k++) begin
            step();
            if (apex_pulse === 1'b1) begin
                apex_n++;
                if (apex_k < 0) begin
                    apex_k = k;
                    apex_p = int'(jump_pos);
                end
            end
            if (land_pulse === 1'b1) land_k = k;
            if (k == 24) jump = 1'b0;
        end
        total++;
        if (apex_k != 24) begin bad++; $display("FAIL full_apex_tick got=%0d want=24", apex_k); end
        total++;
        if (apex_p != 75) begin bad++; $display("FAIL full_apex_pos got=%0d want=75", apex_p); end
        total++;
        if (apex_n != 1) begin bad++; $display("FAIL full_apex_count got=%0d want=1", apex_n); end
        total++;
        if (land_k != 49) begin bad++; $display("FAIL full_land_tick got=%0d want=49", land_k); end
        step();
        total++;
        if ({in_air, land_pulse, jump_pos} !== 9'b0) begin
            bad++;
            $display("FAIL full_after_land got=%b want=0", {in_air, land_pulse, jump_pos});
        end
    endtask

    task automatic test_cut();
        int max_p = 0, apex_k = -1, land_k = -1;
        jump = 1'b1;
        step();
        jump = 1'b0;
        for (int k = 1; k <= 30 && land_k < 0; k++) begin
            step();
            if (int'(jump_pos) > max_p) max_p = int'(jump_pos);
            if (apex_pulse === 1'b1 && apex_k < 0) apex_k = k;
            if (land_pulse === 1'b1) land_k = k;
        end
        total++;
        if (max_p != 9) begin bad++; $display("FAIL cut_peak got=%0d want=9", max_p); end
        total++;
        if (apex_k != 8) begin bad++; $display("FAIL cut_apex_tick got=%0d want=8", apex_k); end
        total++;
        if (land_k != 17) begin bad++; $display("FAIL cut_land_tick got=%0d want=17", land_k); end
        step();
        step();
        total++;
        if (in_air !== 1'b0) begin bad++; $display("FAIL cut_no_rejump got=%b want=0", in_air); end
    endtask

    task automatic test_fast_fall();
        int land_k = -1, prev = 75, mono_viol = 0, fall_viol = 0;
        jump = 1'b1;
        step();
        for (int k = 1; k <= 60 && land_k < 0; k++) begin
            step();
            if (land_pulse === 1'b1) begin
                land_k = k;
            end else if (k >= 24) begin
                if (falling !== 1'b1) fall_viol++;
                if (k > 24 && int'(jump_pos) > prev) mono_viol++;
                prev = int'(jump_pos);
            end
            if (k == 24) jump = 1'b0;
            if (k == 29) duck = 1'b1;
        end
        duck = 1'b0;
        total++;
        if (land_k != 41) begin bad++; $display("FAIL ff_land_tick got=%0d want=41", land_k); end
        total++;
        if (fall_viol != 0) begin bad++; $display("FAIL ff_falling got=%0d bad samples want=0", fall_viol); end
        total++;
        if (mono_viol != 0) begin bad++; $display("FAIL ff_monotonic got=%0d rises want=0", mono_viol); end
        step();
    endtask

    task automatic test_buffer();
        int land_k = -1, nb_apex_n = 0, wait_n = 0;
        jump = 1'b1;
        step();
        for (int k = 1; k <= 60 && land_k < 0; k++) begin
            if (k == 40) jump = 1'b1;
            step();
            if (nb_apex_pulse === 1'b1) nb_apex_n++;
            if (land_pulse === 1'b1) land_k = k;
            if (k == 24 || k == 40) jump = 1'b0;
        end
        total++;
        if (land_k != 49) begin bad++; $display("FAIL buf_land_tick got=%0d want=49", land_k); end
        total++;
        if ({in_air, falling, jump_pos} !== {1'b1, 1'b0, 7'd0}) begin
            bad++;
            $display("FAIL buf_rejump got air=%b fall=%b pos=%0d want air=1 fall=0 pos=0", in_air, falling, jump_pos);
        end
        total++;
        if ({nb_land_pulse, nb_in_air, nb_falling, nb_jump_pos} !== {1'b1, 9'b0}) begin
            bad++;
            $display("FAIL nobuf_ground got land=%b air=%b pos=%0d want land=1 air=0 pos=0", nb_land_pulse, nb_in_air, nb_jump_pos);
        end
        total++;
        if (nb_apex_n != 1) begin bad++; $display("FAIL nobuf_apex_count got=%0d want=1", nb_apex_n); end
        step();
        total++;
        if (jump_pos !== 7'd2) begin bad++; $display("FAIL buf_climb1 got=%0d want=2", jump_pos); end
        step();
        total++;
        if (jump_pos !== 7'd3) begin bad++; $display("FAIL buf_climb2 got=%0d want=3", jump_pos); end
        while (in_air === 1'b1 && wait_n < 40) begin
            step();
            wait_n++;
        end
        total++;
        if (in_air !== 1'b0) begin bad++; $display("FAIL buf_second_land got air=%b want=0", in_air); end
    endtask

    task automatic test_speed_halt();
        int apex_c = -1, land_c = -1, halt_pulses = 0, halt_pos_bad = 0;
        speed = 24'd3;
        jump  = 1'b1;
        step();
        for (int c = 1; c <= 260 && land_c < 0; c++) begin
            step();
            if (apex_pulse === 1'b1 && apex_c < 0) apex_c = c;
            if (land_pulse === 1'b1) land_c = c;
            if (c >= 101 && c <= 110) begin
                if (apex_pulse !== 1'b0 || land_pulse !== 1'b0) halt_pulses++;
                if (jump_pos !== 7'd75) halt_pos_bad++;
            end
            if (c == 96)  jump = 1'b0;
            if (c == 100) halt = 1'b1;
            if (c == 110) halt = 1'b0;
        end
        halt  = 1'b0;
        speed = '0;
        total++;
        if (apex_c != 96) begin bad++; $display("FAIL spd_apex_cycle got=%0d want=96", apex_c); end
        total++;
        if (land_c != 206) begin bad++; $display("FAIL spd_land_cycle got=%0d want=206", land_c); end
        total++;
        if (halt_pulses != 0) begin bad++; $display("FAIL halt_pulses got=%0d want=0", halt_pulses); end
        total++;
        if (halt_pos_bad != 0) begin bad++; $display("FAIL halt_pos_hold got=%0d changes want=0", halt_pos_bad); end
        step();
    endtask

    task automatic test_resets();
        speed = '0;
        jump  = 1'b1;
        step();
        repeat (4) step();
        jump = 1'b0;
        repeat (2) step();
        jump = 1'b1;
        step();
        total++;
        if (u_dut.pending !== 1'b1) begin bad++; $display("FAIL rst_pending_set got=%b want=1", u_dut.pending); end
        game_rst = 1'b1;
        step();
        total++;
        if ({in_air, falling, jump_pos, u_dut.pending} !== 10'b0) begin
            bad++;
            $display("FAIL game_rst_clear got air=%b pos=%0d pend=%b want 0", in_air, jump_pos, u_dut.pending);
        end
        step();
        total++;
        if (in_air !== 1'b0) begin bad++; $display("FAIL game_rst_hold got air=%b want=0", in_air); end
        game_rst = 1'b0;
        step();
        total++;
        if (in_air !== 1'b1) begin bad++; $display("FAIL game_rst_relaunch got air=%b want=1", in_air); end
        repeat (3) step();
        sys_rst_n = 1'b0;
        step();
        total++;
        if ({in_air, jump_pos, u_dut.pending} !== 9'b0) begin
            bad++;
            $display("FAIL sys_rst_clear got air=%b pos=%0d pend=%b want 0", in_air, jump_pos, u_dut.pending);
        end
        sys_rst_n = 1'b1;
        step();
        total++;
        if (in_air !== 1'b1) begin bad++; $display("FAIL sys_rst_relaunch got air=%b want=1", in_air); end
        jump = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_full_jump();
        test_cut();
        test_fast_fall();
        test_buffer();
        test_speed_halt();
        test_resets();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
